// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU: operation classes,
// ALU operation codes and funct3 encodings.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder: ALUOp class plus funct7/funct3
// to a 4-bit ALU operation code.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [3:0] ALUCtrl
);

    logic alt_sel;
    logic unused_funct7;

    assign alt_sel       = funct7[5];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        ALUCtrl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD:    ALUCtrl = ALU_ADD;
            ALUOP_BRANCH: ALUCtrl = ALU_SUB;
            default: begin
                case (funct3)
                    // I-type has no SUB form; funct7[5] only matters for shifts there.
                    F3_ADD_SUB: ALUCtrl = (ALUOp == ALUOP_RTYPE && alt_sel) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     ALUCtrl = ALU_SLL;
                    F3_SLT:     ALUCtrl = ALU_SLT;
                    F3_SLTU:    ALUCtrl = ALU_SLTU;
                    F3_XOR:     ALUCtrl = ALU_XOR;
                    F3_SRL_SRA: ALUCtrl = alt_sel ? ALU_SRA : ALU_SRL;
                    F3_OR:      ALUCtrl = ALU_OR;
                    F3_AND:     ALUCtrl = ALU_AND;
                    default:    ALUCtrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU: control decode, 32-bit datapath and
// registered result/zero/opcode outputs with one cycle of latency.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ALUOp,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic [3:0]  ALUCtrl,
    output logic [31:0] ALUOut,
    output logic        Zero
);

    logic [3:0]  ctrl_d, ctrl_q;
    logic [31:0] out_d, out_q;
    logic        zero_d, zero_q;
    logic [4:0]  shamt;

    alu_ctrl_decode u_decode (
        .ALUOp   (ALUOp),
        .funct7  (funct7),
        .funct3  (funct3),
        .ALUCtrl (ctrl_d)
    );

    assign shamt = in1[4:0];

    always_comb begin
        out_d = 32'd0;
        case (ctrl_d)
            ALU_AND:  out_d = in0 & in1;
            ALU_OR:   out_d = in0 | in1;
            ALU_ADD:  out_d = in0 + in1;
            ALU_XOR:  out_d = in0 ^ in1;
            ALU_SLL:  out_d = in0 << shamt;
            ALU_SRL:  out_d = in0 >> shamt;
            ALU_SUB:  out_d = in0 - in1;
            ALU_SLT:  out_d = {31'd0, ($signed(in0) < $signed(in1))};
            ALU_SLTU: out_d = {31'd0, (in0 < in1)};
            ALU_SRA:  out_d = $unsigned($signed(in0) >>> shamt);
            default:  out_d = 32'd0;
        endcase
    end

    assign zero_d = (out_d == 32'd0);

    // Zero clears in reset so branch logic never sees a taken indication out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= ALU_ADD;
            out_q  <= 32'd0;
            zero_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            out_q  <= out_d;
            zero_q <= zero_d;
        end
    end

    assign ALUCtrl = ctrl_q;
    assign ALUOut  = out_q;
    assign Zero    = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; each task drives one
// scenario and checks {ALUCtrl, ALUOut, Zero} against hand-computed values.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [3:0]  ALUCtrl;
    logic [31:0] ALUOut;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    alu_exec_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ALUOp   (ALUOp),
        .funct7  (funct7),
        .funct3  (funct3),
        .in0     (in0),
        .in1     (in1),
        .ALUCtrl (ALUCtrl),
        .ALUOut  (ALUOut),
        .Zero    (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation at the falling edge, then sample 1 ns after the rising edge.
    task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUOp = op; funct7 = f7; funct3 = f3; in0 = a; in1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ALUOp = 2'b10; funct7 = 7'h00; funct3 = 3'b000; in0 = 32'd7; in1 = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=00000000 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd16, 1'b0}) begin
            errors++;
            $display("FAIL first_after_reset: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=00000010 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_rtype_add;
        run_op(2'b10, 7'b0000000, 3'b000, 32'd10, 32'd20);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd30, 1'b0}) begin
            errors++;
            $display("FAIL rtype_add: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=0000001e zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b10, 7'b0100000, 3'b000, 32'd10, 32'd3);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0110, 32'd7, 1'b0}) begin
            errors++;
            $display("FAIL rtype_sub: got ctrl=%b out=%h zero=%b, want ctrl=0110 out=00000007 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_branch;
        run_op(2'b01, 7'b0000001, 3'b000, 32'd10, 32'd20);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0110, 32'hFFFF_FFF6, 1'b0}) begin
            errors++;
            $display("FAIL branch_ne: got ctrl=%b out=%h zero=%b, want ctrl=0110 out=fffffff6 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b01, 7'b0000001, 3'b000, 32'd20, 32'd20);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0110, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL branch_eq: got ctrl=%b out=%h zero=%b, want ctrl=0110 out=00000000 zero=1",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_shift_compare;
        run_op(2'b10, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b1001, 32'hF800_0000, 1'b0}) begin
            errors++;
            $display("FAIL rtype_sra: got ctrl=%b out=%h zero=%b, want ctrl=1001 out=f8000000 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b10, 7'b0000000, 3'b101, 32'h8000_0000, 32'd4);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0101, 32'h0800_0000, 1'b0}) begin
            errors++;
            $display("FAIL rtype_srl: got ctrl=%b out=%h zero=%b, want ctrl=0101 out=08000000 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        // Shift amount uses only in1[4:0]: 0x23 shifts by 3.
        run_op(2'b10, 7'b0000000, 3'b001, 32'h0000_0011, 32'h0000_0023);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0100, 32'h0000_0088, 1'b0}) begin
            errors++;
            $display("FAIL rtype_sll: got ctrl=%b out=%h zero=%b, want ctrl=0100 out=00000088 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b10, 7'b0000000, 3'b010, 32'hFFFF_FFF8, 32'd1);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0111, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL rtype_slt: got ctrl=%b out=%h zero=%b, want ctrl=0111 out=00000001 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b10, 7'b0000000, 3'b011, 32'hFFFF_FFF8, 32'd1);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b1000, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL rtype_sltu: got ctrl=%b out=%h zero=%b, want ctrl=1000 out=00000000 zero=1",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_logic_ops;
        run_op(2'b10, 7'b1011111, 3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0011, 32'hFF00_EDCB, 1'b0}) begin
            errors++;
            $display("FAIL rtype_xor: got ctrl=%b out=%h zero=%b, want ctrl=0011 out=ff00edcb zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b10, 7'b0000000, 3'b110, 32'hF000_000F, 32'h0F00_00F0);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0001, 32'hFF00_00FF, 1'b0}) begin
            errors++;
            $display("FAIL rtype_or: got ctrl=%b out=%h zero=%b, want ctrl=0001 out=ff0000ff zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b10, 7'b0000000, 3'b111, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0000, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL rtype_and: got ctrl=%b out=%h zero=%b, want ctrl=0000 out=00000000 zero=1",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_itype;
        run_op(2'b11, 7'b0100000, 3'b000, 32'd5, 32'd3);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd8, 1'b0}) begin
            errors++;
            $display("FAIL itype_add: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=00000008 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b11, 7'b0100000, 3'b101, 32'hFFFF_FFF0, 32'd2);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b1001, 32'hFFFF_FFFC, 1'b0}) begin
            errors++;
            $display("FAIL itype_sra: got ctrl=%b out=%h zero=%b, want ctrl=1001 out=fffffffc zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_wrap;
        run_op(2'b00, 7'b0100000, 3'b111, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL add_wrap: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=00000000 zero=1",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_back_to_back;
        run_op(2'b10, 7'b0000000, 3'b000, 32'd100, 32'd1);
        checks++;
        if (ALUOut !== 32'd101) begin
            errors++;
            $display("FAIL b2b_first: got out=%h want 00000065", ALUOut);
        end
        // Inputs changed mid-cycle must not reach the outputs before the next edge.
        in0 = 32'd500; in1 = 32'd500; ALUOp = 2'b01;
        #2;
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd101, 1'b0}) begin
            errors++;
            $display("FAIL b2b_hold: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=00000065 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0110, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second: got ctrl=%b out=%h zero=%b, want ctrl=0110 out=00000000 zero=1",
                     ALUCtrl, ALUOut, Zero);
        end
        run_op(2'b10, 7'b0000000, 3'b001, 32'd1, 32'd31);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0100, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL b2b_third: got ctrl=%b out=%h zero=%b, want ctrl=0100 out=80000000 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    task automatic test_mid_reset;
        run_op(2'b10, 7'b0000000, 3'b110, 32'h1234_0000, 32'h0000_5678);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_immediate: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=00000000 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0010, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_hold: got ctrl=%b out=%h zero=%b, want ctrl=0010 out=00000000 zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b10, 7'b0100000, 3'b000, 32'd3, 32'd5);
        checks++;
        if ({ALUCtrl, ALUOut, Zero} !== {4'b0110, 32'hFFFF_FFFE, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_release: got ctrl=%b out=%h zero=%b, want ctrl=0110 out=fffffffe zero=0",
                     ALUCtrl, ALUOut, Zero);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_branch();
        test_shift_compare();
        test_logic_ops();
        test_itype();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
